// File: rtl/soc_mem_pkg.sv
// Shared types and constants for the SoC RAM responder.
// Optional stats counters are enabled by SOC_RAM_ACCESS_STATS_EN.
package soc_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      COMMIT,
      RESP
   } state_e;

   localparam int WORD_BYTES      = 4;
   localparam int MAX_WAIT_STATES = 15;
   localparam int WAIT_CNT_W      = 4;

   function automatic logic [WAIT_CNT_W-1:0] wait_load(input int unsigned ws);
      return (ws > 0) ? WAIT_CNT_W'(ws - 1) : '0;
   endfunction

endpackage

// File: rtl/soc_mem_bus_if.sv
// SoC memory bus: master drives request attributes,
// slave returns registered read data and a one-cycle valid.
interface SoC_MemBus;

   logic [31:0] addr;
   logic [31:0] write_data;
   logic        write_en;
   logic [3:0]  byte_en;
   logic        req;
   logic [31:0] read_data;
   logic        valid;

   modport Master (
      output addr, write_data, write_en, byte_en, req,
      input  read_data, valid
   );

   modport Slave (
      input  addr, write_data, write_en, byte_en, req,
      output read_data, valid
   );

endinterface

// File: rtl/soc_ram_array.sv
// Single-port word RAM with byte-lane writes and registered read.
// No reset on storage or read register so it maps onto block RAM.
module soc_ram_array
   import soc_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [WORD_BYTES-1:0] we,
   input  logic [IDX_W-1:0]      idx,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (|we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
               if (we[b]) begin
                  mem[idx][8*b +: 8] <= wdata[8*b +: 8];
               end
            end
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/soc_ram_responder.sv
// SoC_MemBus slave backed by a word RAM with programmable wait states.
// Define SOC_RAM_ACCESS_STATS_EN to add read_count/write_count outputs.
module soc_ram_responder
   import soc_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        res,
   SoC_MemBus.Slave    bus
`ifdef SOC_RAM_ACCESS_STATS_EN
   ,
   output logic [31:0] read_count,
   output logic [31:0] write_count
`endif
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_STATES);

   state_e                  state_q, state_d;
   logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    wr_q;
   logic [WORD_BYTES-1:0]   be_q;
   logic [31:0]             wdata_q;
   logic                    rd_ok_q;
   logic                    commit;
   logic                    accept;
   logic                    ram_en;
   logic [WORD_BYTES-1:0]   ram_we;
   logic [31:0]             ram_rdata;

   // BASE_ADDR is word aligned, so subtracting on word bits is exact
   assign idx_d  = bus.addr[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];
   assign accept = (state_q == IDLE) && bus.req && !res;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req) begin
               state_d = (WAIT_STATES > 0) ? WAIT : COMMIT;
               cnt_d   = WAIT_LOAD;
            end
         end
         WAIT: begin
            if (!bus.req) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = COMMIT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         COMMIT: begin
            if (!bus.req) begin
               state_d = IDLE;
            end else begin
               commit  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (res) begin
         state_d = IDLE;
         cnt_d   = '0;
         commit  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_ok_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (commit && !wr_q) begin
            rd_ok_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         idx_q   <= idx_d;
         wr_q    <= bus.write_en;
         be_q    <= bus.byte_en;
         wdata_q <= bus.write_data;
      end
   end

   // A write with no lanes enabled must not disturb the read register
   assign ram_en = commit && !(wr_q && (be_q == '0));
   assign ram_we = wr_q ? be_q : '0;

   soc_ram_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   assign bus.valid     = (state_q == RESP);
   assign bus.read_data = rd_ok_q ? ram_rdata : 32'h0;

`ifdef SOC_RAM_ACCESS_STATS_EN
   logic [31:0] rcnt_q, rcnt_d;
   logic [31:0] wcnt_q, wcnt_d;

   always_comb begin
      rcnt_d = rcnt_q;
      wcnt_d = wcnt_q;
      if (commit) begin
         if (wr_q) begin
            wcnt_d = wcnt_q + 32'd1;
         end else begin
            rcnt_d = rcnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         rcnt_q <= '0;
         wcnt_q <= '0;
      end else begin
         rcnt_q <= rcnt_d;
         wcnt_q <= wcnt_d;
      end
   end

   assign read_count  = rcnt_q;
   assign write_count = wcnt_q;
`endif

endmodule

// File: tb/tb_soc_ram_responder.sv
// Randomized self-checking bench for soc_ram_responder.
// Three instances: no wait states, three wait states, small aliased window.
module tb_soc_ram_responder;

   logic clk;
   logic r0, r3, ra;
   int   checks;
   int   errors;

   SoC_MemBus b0 ();
   SoC_MemBus b3 ();
   SoC_MemBus ba ();

`ifdef SOC_RAM_ACCESS_STATS_EN
   logic [31:0] rc0, wc0, rc3, wc3, rca, wca;
`endif

   soc_ram_responder #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_STATES (0)
   ) u0 (
      .clk (clk),
      .res (r0),
      .bus (b0)
`ifdef SOC_RAM_ACCESS_STATS_EN
      ,
      .read_count  (rc0),
      .write_count (wc0)
`endif
   );

   soc_ram_responder #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_STATES (3)
   ) u3 (
      .clk (clk),
      .res (r3),
      .bus (b3)
`ifdef SOC_RAM_ACCESS_STATS_EN
      ,
      .read_count  (rc3),
      .write_count (wc3)
`endif
   );

   soc_ram_responder #(
      .DEPTH_WORDS (16),
      .BASE_ADDR   (32'h0000_1000),
      .WAIT_STATES (0)
   ) ua (
      .clk (clk),
      .res (ra),
      .bus (ba)
`ifdef SOC_RAM_ACCESS_STATS_EN
      ,
      .read_count  (rca),
      .write_count (wca)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: word store keyed by (instance, word index)
   logic [31:0] mdl [int];
   logic [31:0] lastrd [3];
   int          ws [3] = '{0, 3, 0};

   function automatic int key(input int d, input logic [31:0] a);
      logic [31:0] base;
      logic [31:0] depth;
      base  = (d == 2) ? 32'h1000 : 32'h0;
      depth = (d == 2) ? 32'd16 : 32'd1024;
      return d * 4096 + int'(((a - base) / 4) % depth);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old & ~m) | (wd & m);
   endfunction

   function automatic logic [31:0] mget(input int k);
      return mdl.exists(k) ? mdl[k] : 32'h0;
   endfunction

   function automatic logic get_valid(input int d);
      case (d)
         0: return b0.valid;
         1: return b3.valid;
         default: return ba.valid;
      endcase
   endfunction

   function automatic logic [31:0] get_rdata(input int d);
      case (d)
         0: return b0.read_data;
         1: return b3.read_data;
         default: return ba.read_data;
      endcase
   endfunction

   task automatic drive(input int d, input logic [31:0] a, input logic w,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic rq);
      case (d)
         0: begin
            b0.addr = a; b0.write_en = w; b0.byte_en = be;
            b0.write_data = wd; b0.req = rq;
         end
         1: begin
            b3.addr = a; b3.write_en = w; b3.byte_en = be;
            b3.write_data = wd; b3.req = rq;
         end
         default: begin
            ba.addr = a; ba.write_en = w; ba.byte_en = be;
            ba.write_data = wd; ba.req = rq;
         end
      endcase
   endtask

   task automatic set_req(input int d, input logic v);
      case (d)
         0: b0.req = v;
         1: b3.req = v;
         default: ba.req = v;
      endcase
   endtask

   task automatic set_res(input int d, input logic v);
      case (d)
         0: r0 = v;
         1: r3 = v;
         default: ra = v;
      endcase
   endtask

   task automatic pulse_res(input int d);
      @(negedge clk);
      set_res(d, 1'b1);
      @(negedge clk);
      set_res(d, 1'b0);
      lastrd[d] = 32'h0;
   endtask

   task automatic txn(input int d, input logic [31:0] a, input logic w,
                      input logic [3:0] be, input logic [31:0] wd,
                      output logic [31:0] rd, output int lat);
      @(negedge clk);
      drive(d, a, w, be, wd, 1'b1);
      lat = -1;
      rd  = 32'h0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (get_valid(d) === 1'b1) begin
            lat = n;
            rd  = get_rdata(d);
            break;
         end
      end
      set_req(d, 1'b0);
   endtask

   task automatic op(input int d, input logic [31:0] a, input logic w,
                     input logic [3:0] be, input logic [31:0] wd,
                     input string tag);
      logic [31:0] rd, exp;
      int lat, k;
      k = key(d, a);
      txn(d, a, w, be, wd, rd, lat);
      checks++;
      if (lat !== ws[d] + 2) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", tag, lat, ws[d] + 2);
      end
      if (w) begin
         mdl[k] = merge(mget(k), wd, be);
         exp = lastrd[d];
      end else begin
         exp = mget(k);
         lastrd[d] = exp;
      end
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL %s read_data: got %h want %h", tag, rd, exp);
      end
      @(negedge clk);
      checks++;
      if (get_valid(d) !== 1'b0 || get_rdata(d) !== exp) begin
         errors++;
         $display("FAIL %s pulse/hold: valid=%b data=%h want 0/%h",
                  tag, get_valid(d), get_rdata(d), exp);
      end
   endtask

   task automatic test_reset;
      r0 = 1'b1; r3 = 1'b1; ra = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(2, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      r0 = 1'b0; r3 = 1'b0; ra = 1'b0;
      for (int d = 0; d < 3; d++) begin
         lastrd[d] = 32'h0;
         checks++;
         if (get_valid(d) !== 1'b0 || get_rdata(d) !== 32'h0) begin
            errors++;
            $display("FAIL reset_state[%0d]: valid=%b data=%h want 0/0",
                     d, get_valid(d), get_rdata(d));
         end
      end
   endtask

   task automatic test_byte_lanes;
      op(0, 32'h10, 1, 4'hF, 32'hDEADBEEF, "wr_full");
      op(0, 32'h10, 0, 4'h0, 32'h0, "rd_full");
      checks++;
      if (lastrd[0] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_full_const: got %h want deadbeef", lastrd[0]);
      end
      op(0, 32'h10, 1, 4'b0010, 32'h0000AA00, "wr_lane1");
      op(0, 32'h10, 0, 4'hF, 32'h0, "rd_lane1");
      op(0, 32'h10, 1, 4'b0000, 32'hFFFFFFFF, "wr_none");
      op(0, 32'h13, 0, 4'h0, 32'h0, "rd_none");
      checks++;
      if (b0.read_data !== 32'hDEADAAEF) begin
         errors++;
         $display("FAIL lane_const: got %h want deadaaef", b0.read_data);
      end
   endtask

   task automatic test_random;
      logic [31:0] a;
      for (int k = 0; k < 8; k++) begin
         op(0, 32'h100 + 32'(4 * k), 1, 4'hF, $urandom, "rnd_init");
      end
      for (int i = 0; i < 40; i++) begin
         a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
         op(0, a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, "rnd_op");
      end
   endtask

   task automatic test_wait_states;
      op(1, 32'h10, 1, 4'hF, $urandom, "ws3_wr");
      op(1, 32'h20, 1, 4'hF, 32'h0BADF00D, "ws3_wr20");
      op(1, 32'h10, 0, 4'hF, 32'h0, "ws3_rd");
   endtask

   task automatic test_back_to_back;
      int hits[$];
      logic [31:0] exp;
      exp = mget(key(1, 32'h10));
      @(negedge clk);
      drive(1, 32'h10, 0, 4'hF, 32'h0, 1'b1);
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (b3.valid === 1'b1) begin
            hits.push_back(n);
            checks++;
            if (b3.read_data !== exp) begin
               errors++;
               $display("FAIL b2b_data: got %h want %h", b3.read_data, exp);
            end
         end
      end
      set_req(1, 1'b0);
      lastrd[1] = exp;
      checks++;
      if (hits.size() != 5) begin
         errors++;
         $display("FAIL b2b_count: got %0d want 5", hits.size());
      end
      for (int i = 0; i < hits.size(); i++) begin
         checks++;
         if (hits[i] != 5 + 6 * i) begin
            errors++;
            $display("FAIL b2b_cycle[%0d]: got %0d want %0d", i, hits[i], 5 + 6 * i);
         end
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_abort;
      int seen;
      // drop req while waiting
      @(negedge clk);
      drive(1, 32'h20, 1, 4'hF, 32'h12345678, 1'b1);
      repeat (2) @(negedge clk);
      set_req(1, 1'b0);
      seen = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (b3.valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_valid: got %0d pulses want 0", seen);
      end
      op(1, 32'h20, 0, 4'hF, 32'h0, "abort_rd");
      // reset during wait, then reset coinciding with the commit edge
      for (int c = 3; c <= 4; c++) begin
         @(negedge clk);
         drive(1, 32'h20, 1, 4'hF, 32'h12345678, 1'b1);
         repeat (c) @(negedge clk);
         r3 = 1'b1;
         @(negedge clk);
         r3 = 1'b0;
         set_req(1, 1'b0);
         lastrd[1] = 32'h0;
         checks++;
         if (b3.valid !== 1'b0 || b3.read_data !== 32'h0) begin
            errors++;
            $display("FAIL res_state[c%0d]: valid=%b data=%h want 0/0",
                     c, b3.valid, b3.read_data);
         end
         seen = 0;
         for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (b3.valid === 1'b1) seen++;
         end
         checks++;
         if (seen != 0) begin
            errors++;
            $display("FAIL res_valid[c%0d]: got %0d pulses want 0", c, seen);
         end
         op(1, 32'h20, 0, 4'hF, 32'h0, "res_rd");
         checks++;
         if (b3.read_data !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL res_old[c%0d]: got %h want 0badf00d", c, b3.read_data);
         end
      end
   endtask

   task automatic test_alias;
      op(2, 32'h1000, 1, 4'hF, 32'hA5A5A5A5, "al_wr");
      op(2, 32'h1040, 0, 4'hF, 32'h0, "al_rd40");
      checks++;
      if (ba.read_data !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL alias_1040: got %h want a5a5a5a5", ba.read_data);
      end
      op(2, 32'h1003, 0, 4'hF, 32'h0, "al_rd03");
      for (int k = 1; k < 16; k++) begin
         op(2, 32'h1000 + 32'(4 * k), 1, 4'hF, $urandom, "al_init");
      end
      for (int i = 0; i < 24; i++) begin
         op(2, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, "al_rnd");
      end
   endtask

`ifdef SOC_RAM_ACCESS_STATS_EN
   task automatic test_stats;
      int nr, nw;
      nr = 0;
      nw = 0;
      pulse_res(0);
      for (int i = 0; i < 3; i++) begin
         op(0, 32'h100 + 32'(4 * i), 1, 4'($urandom), $urandom, "st_wr");
         nw++;
      end
      for (int i = 0; i < 2; i++) begin
         op(0, 32'h104, 0, 4'hF, 32'h0, "st_rd");
         nr++;
      end
      @(negedge clk);
      drive(0, 32'h104, 0, 4'hF, 32'h0, 1'b1);
      @(negedge clk);
      set_req(0, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (rc0 !== 32'(nr) || wc0 !== 32'(nw)) begin
         errors++;
         $display("FAIL stats_count: r=%0d w=%0d want r=%0d w=%0d", rc0, wc0, nr, nw);
      end
      pulse_res(0);
      checks++;
      if (rc0 !== 32'h0 || wc0 !== 32'h0) begin
         errors++;
         $display("FAIL stats_reset: r=%0d w=%0d want 0/0", rc0, wc0);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_byte_lanes();
      test_random();
      test_wait_states();
      test_back_to_back();
      test_abort();
      test_alias();
`ifdef SOC_RAM_ACCESS_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
